// File: rtl/axi_line_refill.sv
// Cache line refill engine: one AXI4 INCR read burst per request, assembled into a full line.
// Bus errors, wrong IDs, early rlast and overlong bursts all flag the returned line as corrupt.
module axi_line_refill #(
    parameter int unsigned BEATS = 4,
    parameter logic [3:0]  ID    = 4'h1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [64*BEATS-1:0]   resp_data,
    output logic                  resp_err,
    output logic [31:0]           araddr,
    output logic [3:0]            arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [63:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned   CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST      = CW'(BEATS - 1);
    localparam logic [31:0]   LINE_MASK = 32'(8 * BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [64*BEATS-1:0] line_q, line_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                beat_hs;

    assign beat_hs = rvalid && rready_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_AR;
                    addr_d  = req_addr & ~LINE_MASK;
                    line_d  = '0;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_AR: begin
                if (arvalid_q && arready) state_d = S_R;
            end
            S_R: begin
                if (beat_hs) begin
                    // full_q marks slot BEATS-1 as written; later beats are dropped
                    if (full_q) begin
                        err_d = 1'b1;
                    end else begin
                        line_d[64*int'(cnt_q) +: 64] = rdata;
                        if (cnt_q == LAST) full_d = 1'b1;
                        else               cnt_d  = cnt_q + 1'b1;
                    end
                    if (rresp != 2'b00 || rid != ID) err_d = 1'b1;
                    if (rlast) begin
                        state_d = S_RESP;
                        if (full_q || cnt_q != LAST) err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (resp_ready) state_d = S_IDLE;
            end
        endcase

        arvalid_d    = (state_d == S_AR);
        // rready rises one cycle after entering R, giving resp_valid at T+3+BEATS
        rready_d     = (state_q == S_R) && (state_d == S_R);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            err_q        <= err_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign araddr     = addr_q;
    assign arid       = ID;
    assign arlen      = 8'(BEATS - 1);
    assign arsize     = 3'b011;
    assign arburst    = 2'b01;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = line_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_axi_line_refill.sv
// Directed bench for axi_line_refill (BEATS=4): table of transactions driven by a bus-slave
// task, plus hand-written backpressure and mid-burst reset sequences.
module tb_axi_line_refill;

    localparam logic [3:0] TID = 4'h1;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [255:0] resp_data;
    logic         resp_err;
    logic [31:0]  araddr;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [3:0]   rid = '0;
    logic [63:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;

    int unsigned total = 0;
    int unsigned bad = 0;

    axi_line_refill #(.BEATS(4), .ID(TID)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0]  addr;
        int unsigned  nb;
        int unsigned  rlast_at;
        int unsigned  err_beat;
        logic [1:0]   err_resp;
        logic [3:0]   err_rid;
        int unsigned  ar_wait;
        bit           gap;
        logic [31:0]  exp_araddr;
        logic [255:0] exp_data;
        bit           exp_err;
        int unsigned  lat;
    } vec_t;

    localparam logic [255:0] D4 = {64'h44, 64'h33, 64'h22, 64'h11};
    localparam logic [255:0] D2 = {64'h0, 64'h0, 64'h22, 64'h11};
    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int unsigned resp_wait, input bit hold_req);
        int unsigned cyc = 0;
        int unsigned b = 0;
        int unsigned ar_seen = 0;
        int unsigned rw = 0;
        bit ar_done = 0;
        bit done = 0;
        bit resp_seen = 0;
        bit idle_next = 0;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        @(negedge aclk);
        cyc = 1;
        req_valid = 1'b0;
        while (!done && cyc < 200) begin
            chk("out_excl", $onehot0({arvalid, rready, resp_valid}), 1);
            // read channel: rvalid only drops after a handshake
            if (ar_done && b < v.nb && !idle_next) begin
                rvalid = 1'b1;
                rdata  = 64'h11 * 64'(b + 1);
                rlast  = (b == v.rlast_at);
                rresp  = (b == v.err_beat) ? v.err_resp : 2'b00;
                rid    = (b == v.err_beat) ? v.err_rid : TID;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                idle_next = 0;
            end
            if (rvalid && rready) begin
                b++;
                idle_next = v.gap;
            end
            if (arvalid && !ar_done) begin
                if (ar_seen == 0 && v.lat != 0) chk("ar_lat", cyc, 1);
                chk("araddr", araddr, v.exp_araddr);
                chk("arlen", arlen, 3);
                chk("arsize", arsize, 3'b011);
                chk("arburst", arburst, 2'b01);
                chk("arid", arid, TID);
                arready = (ar_seen >= v.ar_wait);
                ar_seen++;
                if (arready) ar_done = 1;
            end else begin
                arready = 1'b0;
            end
            if (resp_valid) begin
                if (!resp_seen) begin
                    resp_seen = 1;
                    if (v.lat != 0) chk("resp_lat", cyc, v.lat);
                end
                chk("resp_data", resp_data, v.exp_data);
                chk("resp_err", resp_err, v.exp_err);
                if (hold_req) chk("req_ready_busy", req_ready, 0);
                req_valid  = hold_req;
                resp_ready = (rw >= resp_wait);
                rw++;
                if (resp_ready) done = 1;
            end else begin
                resp_ready = 1'b0;
            end
            @(negedge aclk);
            cyc++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL txn_timeout: got no response after %0d cycles, required one", cyc);
        end
        resp_ready = 1'b0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        arready    = 1'b0;
        if (!hold_req) req_valid = 1'b0;
        chk("resp_valid_drop", resp_valid, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_resp_data", resp_data, 0);
    endtask

    initial begin
        vecs[0] = '{32'h8000_0014, 4, 3, 99, 2'b00, TID,   0, 0, 32'h8000_0000, D4, 0, 7};
        vecs[1] = '{32'h1234_567F, 4, 3, 99, 2'b00, TID,   5, 1, 32'h1234_5660, D4, 0, 0};
        vecs[2] = '{32'h0000_0020, 4, 3,  2, 2'b10, TID,   0, 0, 32'h0000_0020, D4, 1, 7};
        vecs[3] = '{32'h0000_0047, 2, 1, 99, 2'b00, TID,   0, 0, 32'h0000_0040, D2, 1, 5};
        vecs[4] = '{32'hFFFF_FFFF, 6, 5, 99, 2'b00, TID,   0, 0, 32'hFFFF_FFE0, D4, 1, 9};
        vecs[5] = '{32'h0000_1008, 4, 3,  0, 2'b00, 4'h2,  0, 0, 32'h0000_1000, D4, 1, 7};

        repeat (3) @(negedge aclk);
        chk_reset_outputs();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_req_ready", req_ready, 1);

        for (int i = 0; i < NV; i++) run_txn(vecs[i], 0, 0);

        // response backpressure with a request waiting, then immediate second request
        run_txn(vecs[0], 4, 1);
        run_txn(vecs[2], 0, 0);

        // reset asserted while beat 2 is on the bus
        begin
            int unsigned b = 0;
            int unsigned cyc = 0;
            req_valid = 1'b1;
            req_addr  = 32'h8000_0014;
            @(negedge aclk);
            req_valid = 1'b0;
            arready   = 1'b1;
            while (b < 2 && cyc < 50) begin
                rvalid = !arvalid;
                rdata  = 64'h11 * 64'(b + 1);
                rid    = TID;
                rresp  = 2'b00;
                if (rvalid && rready) b++;
                @(negedge aclk);
                cyc++;
            end
            chk("rst_seq_beats", b, 2);
            rvalid  = 1'b1;
            rdata   = 64'h33;
            aresetn = 1'b0;
            @(negedge aclk);
            aresetn = 1'b1;
            chk_reset_outputs();
            chk("rst_req_ready_mid", req_ready, 1);
            arready = 1'b0;
            @(negedge aclk);
            repeat (2) begin
                chk("rst_no_rready", rready, 0);
                @(negedge aclk);
            end
            rvalid = 1'b0;
        end
        run_txn(vecs[0], 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_line_refill.md
AXI_LINE_REFILL -- requirements
Module: axi_line_refill

Interface
REQ-001 SHALL have parameter BEATS, default 4: number of 64-bit beats per line (power of two, 2..16).
REQ-002 SHALL have parameter ID, default 4'h1: AXI transaction ID driven on arid and expected on rid.
REQ-003 aclk  input  1  clock; all state updates on rising edge.
REQ-004 aresetn  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  line refill request from the cache.
REQ-006 req_ready  output  1  engine idle and able to accept a request.
REQ-007 req_addr  input  32  byte address of any byte within the requested line.
REQ-008 resp_valid  output  1  refilled line available.
REQ-009 resp_ready  input  1  cache consumes the response.
REQ-010 resp_data  output  64*BEATS  line data; beat i at bits [64*i+63:64*i].
REQ-011 resp_err  output  1  line is corrupt (bus error or protocol violation).
REQ-012 araddr  output  32  AXI read address, line-aligned.
REQ-013 arid  output  4  AXI read ID, constant ID.
REQ-014 arlen  output  8  AXI burst length, constant BEATS-1.
REQ-015 arsize  output  3  AXI beat size, constant 3'b011 (8 bytes).
REQ-016 arburst  output  2  AXI burst type, constant 2'b01 (INCR).
REQ-017 arvalid  output  1  read address valid.
REQ-018 arready  input  1  read address accepted by the slave.
REQ-019 rid  input  4  read data ID.
REQ-020 rdata  input  64  read beat data.
REQ-021 rresp  input  2  read beat response; 2'b00 = OKAY.
REQ-022 rlast  input  1  final beat of the burst.
REQ-023 rvalid  input  1  read beat valid.
REQ-024 rready  output  1  engine accepts the read beat.

Function
REQ-025 SHALL implement a four-state FSM: IDLE -> AR -> R -> RESP -> IDLE.
REQ-026 IDLE: req_ready=1; on req_valid&&req_ready SHALL latch req_addr with its low log2(8*BEATS) bits cleared, clear the line buffer, beat counter and err flag, and enter AR.
REQ-027 AR: arvalid=1 from the cycle after acceptance, with araddr, arlen, arsize, arburst and arid stable until arready; on arvalid&&arready SHALL enter R next cycle, with arvalid=0 in R.
REQ-028 R: rready=1; each rvalid&&rready beat SHALL be written to line slot cnt, then cnt+1; cnt SHALL saturate at BEATS-1.
REQ-029 Any accepted beat with rresp!=2'b00 or rid!=ID SHALL set the sticky err flag; the data is stored regardless.
REQ-030 rlast on an accepted beat SHALL move R to RESP; if cnt!=BEATS-1 at that beat (early rlast), err SHALL be set; unfilled slots remain zero.
REQ-031 Accepted beats after slot BEATS-1 without rlast SHALL be discarded, SHALL set err, and SHALL NOT overwrite slot BEATS-1; the FSM stays in R until rlast.
REQ-032 RESP: resp_valid=1, with resp_data and resp_err stable until resp_ready; on resp_valid&&resp_ready SHALL enter IDLE; req_ready rises the following cycle.
REQ-033 req_ready SHALL be 0 in every state except IDLE; only one burst is outstanding at a time.
REQ-034 Minimum latency: acceptance at cycle T, arvalid at T+1; with zero-wait slave, resp_valid at T+3+BEATS.
REQ-035 arvalid, rready and resp_valid SHALL be registered outputs that are never asserted simultaneously.

Reset
REQ-036 With aresetn=0 at a clock edge, the FSM SHALL go to IDLE; arvalid, rready, resp_valid and resp_err SHALL be 0; araddr, resp_data and cnt SHALL be 0; req_ready SHALL be 1 from the first edge after release.
REQ-037 Reset in AR, R or RESP SHALL abandon the transaction without a response; in-flight slave beats after release are not accepted (rready=0).

Verification
REQ-038 BEATS=4, req_addr=0x8000_0014, zero-wait slave returning 0x11..0x44 -> araddr=0x8000_0000, arlen=3, resp_data={0x44,0x33,0x22,0x11}, resp_err=0, resp_valid 7 cycles after acceptance.
REQ-039 arready held low 5 cycles, rvalid gapped every other cycle -> AR fields stable throughout, beats stored in order, resp_err=0.
REQ-040 Beat 2 with rresp=2'b10 -> resp_err=1, all four slots still filled.
REQ-041 rlast on beat 1 -> RESP after 2 beats, slots 2..3 = 0, resp_err=1; 6-beat burst with rlast on beat 5 -> slot 3 holds beat 3, resp_err=1.
REQ-042 resp_ready low for 4 cycles with req_valid high -> resp_valid held, req_ready=0, second request accepted 1 cycle after resp handshake.
REQ-043 aresetn pulsed low during beat 2 -> next cycle IDLE, all outputs at reset values, next request completes normally.
